// File: rtl/cellrv32_io_initiator.sv
// ============================================================================
// cellrv32_io_initiator
//
// Single-outstanding bus initiator for the CELLRV32 IO-peripheral space.
// It takes one request from a valid/ready channel (debug host, DMA, test
// port) and turns it into one strobed IO transfer. It then waits for the
// responder's ack, with a timeout. The result goes back on a valid/ready
// response channel.
//
// Parameters
//   TIMEOUT_CYCLES  WAIT cycles without ack before a bus error (1..255)
//
// Optional feature
//   CELLRV32_IO_INIT_ALIGN_CHECK_EN  when defined, a request whose address is
//                                    not word aligned gets an immediate error
//                                    response and issues no bus strobe.
//
// Ports
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_we_i                 1 = write, 0 = read
//   req_addr_i, req_wdata_i  request byte address and write data
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_rdata_o              read data (0 for writes and errors)
//   rsp_err_o                timeout / alignment error
//   bus_addr_o, bus_data_o   IO address and write data, held through WAIT
//   bus_rden_o, bus_wren_o   single-cycle read / write strobes
//   bus_data_i, bus_ack_i    OR-combined IO read data and acknowledge
// ============================================================================
module cellrv32_io_initiator #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    // request channel
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    // response channel
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    // IO bus
    output logic [31:0] bus_addr_o,
    output logic        bus_rden_o,
    output logic        bus_wren_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("cellrv32_io_initiator: TIMEOUT_CYCLES must be in 1..255");
    end

    // Counter value seen in the last WAIT cycle before the timeout fires.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e      state_q,     state_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic        we_q,        we_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q,   rsp_err_d;
    logic [31:0] bus_addr_q,  bus_addr_d;
    logic        bus_rden_q,  bus_rden_d;
    logic        bus_wren_q,  bus_wren_d;
    logic [31:0] bus_data_q,  bus_data_d;
    logic        misaligned;

`ifdef CELLRV32_IO_INIT_ALIGN_CHECK_EN
    assign misaligned = (req_addr_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every _d gets a default before the case statement, so no path
    // leaves a variable unassigned and no latch is inferred. Combinational
    // code uses blocking assignments.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        bus_addr_d  = bus_addr_q;
        bus_data_d  = bus_data_q;
        // Strobes are single-cycle pulses. They are set only on the way into ISSUE.
        bus_rden_d  = 1'b0;
        bus_wren_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // req_ready_q is always 1 in IDLE, so a valid request is accepted here.
                if (req_valid_i) begin
                    we_d        = req_we_i;
                    req_ready_d = 1'b0;
                    if (misaligned) begin
                        // Alignment error: skip the bus and answer right away.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'h0;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = ST_ISSUE;
                        bus_addr_d = req_addr_i;
                        bus_data_d = req_wdata_i;
                        bus_rden_d = ~req_we_i;
                        bus_wren_d = req_we_i;
                    end
                end
            end

            ST_ISSUE: begin
                cnt_d = 8'h0;
                // A responder that acks combinationally in the strobe cycle is honoured.
                if (bus_ack_i) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'h0 : bus_data_i;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q + 8'h1;
                // Ack is checked first, so an ack on the expiry cycle wins over the timeout.
                if (bus_ack_i) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'h0 : bus_data_i;
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b1;
                end
            end

            ST_RESP: begin
                // Any ack arriving here is late (after a timeout) and is dropped.
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    // NOTE: reset is asynchronous, so a mid-transfer reset drops the strobes
    // and the pending response at once, without waiting for a clock edge.
    // Sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'h0;
            we_q        <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_rden_q  <= 1'b0;
            bus_wren_q  <= 1'b0;
            bus_data_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            bus_addr_q  <= bus_addr_d;
            bus_rden_q  <= bus_rden_d;
            bus_wren_q  <= bus_wren_d;
            bus_data_q  <= bus_data_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_rden_o  = bus_rden_q;
    assign bus_wren_o  = bus_wren_q;
    assign bus_data_o  = bus_data_q;

endmodule
